frame_bram_pingpong: RTL and testbench
======================================

Name: frame_bram_pingpong

Overview:
- Single-clock, double-buffered frame memory for the camera capture path.
- Successor to the dual-clock mem_bram: parametrised width, depth and read latency, with two banks.
- The writer fills one bank while the display reader scans the other.
- Banks swap only on a frame-boundary handshake, so the reader never sees a torn frame.

Parameters:
- WIDTH, 12, pixel data width in bits.
- DEPTH, 307200 (640*480), words per bank.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2. Any other value is an elaboration error.
- ADDR_W is a derived localparam equal to $clog2(DEPTH).

Ports:
- i_clk  in  1  system clock, all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  block enable; gates all reads, writes and state changes.
- i_wr  in  1  write strobe.
- i_wr_addr  in  ADDR_W  write address within the current write bank.
- i_wr_data  in  WIDTH  write data.
- i_wr_frame_end  in  1  one-cycle pulse marking that the write bank holds a complete frame.
- i_rd  in  1  read strobe.
- i_rd_addr  in  ADDR_W  read address within the current read bank.
- i_rd_frame_start  in  1  one-cycle pulse: reader is at a frame boundary and accepts a swap.
- o_rd_data  out  WIDTH  read data.
- o_rd_valid  out  1  high with the data for an accepted read.
- o_wr_bank  out  1  bank currently being written.
- o_rd_bank  out  1  bank currently being read.
- o_frame_ready  out  1  at least one complete frame has been presented to the reader.
- o_overrun  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset values: o_wr_bank=0, o_rd_bank=1, o_frame_ready=0, o_overrun=0, o_rd_valid=0, o_rd_data=0, state=EMPTY, read pipeline cleared.
- Reset does not clear memory contents. A reset mid-frame discards any pending swap.
- States:
  - EMPTY: no frame yet. Writes are accepted to the write bank.
  - FILL: a frame is being presented to the reader. Writes are accepted.
  - WAIT_SWAP: the write bank holds a full frame; the block waits for the reader.
- Transitions:
  - EMPTY, on i_wr_frame_end -> WAIT_SWAP.
  - FILL, on i_wr_frame_end -> WAIT_SWAP.
  - WAIT_SWAP, on i_rd_frame_start -> FILL. On the same edge: o_rd_bank<=o_wr_bank, o_wr_bank<=~o_wr_bank, o_frame_ready<=1.
- i_rd_frame_start in EMPTY or FILL is ignored; no swap occurs.
- i_wr_frame_end in WAIT_SWAP is ignored.
- Simultaneous i_wr_frame_end and i_rd_frame_start in FILL: go to WAIT_SWAP only. The swap happens on a later i_rd_frame_start.
- Writes:
  - Accepted when i_en & i_wr & state!=WAIT_SWAP & i_wr_addr<DEPTH.
  - Written at the rising edge to bank o_wr_bank.
  - A write cycle carrying i_wr_frame_end is performed before the state change.
  - A write in WAIT_SWAP is dropped and sets o_overrun, including a write on the swap edge itself.
- Reads:
  - Accepted when i_en & i_rd.
  - The bank is o_rd_bank as sampled at the issuing edge; a read on the swap edge reads the pre-swap bank.
  - o_rd_data and o_rd_valid appear RD_LATENCY cycles after the issuing edge.
  - A read with i_rd_addr>=DEPTH returns 0 with valid=1.
  - Reads are allowed in every state, including EMPTY (contents undefined).
- Same-bank collision is impossible by construction: the write bank always differs from the read bank.
- i_en low: no memory access, no state or bank change. o_rd_valid=0 on the following output cycle; o_rd_data holds. Frame pulses arriving while i_en is low are ignored.
- The read pipeline stalls only via i_en; reads already in flight still complete.

Optional Feature:
- Macro FRAME_BRAM_DROP_CNT_EN.
- Defined: adds port o_drop_cnt out 16, a saturating count of dropped writes.
  - Reset value 0.
  - Increments by 1 per dropped write and holds at 16'hFFFF.
  - o_overrun is unchanged.
- Undefined: the port and the counter are absent; only the o_overrun flag exists.

Decomposition:
- Package frame_bram_pkg holds:
  - the state encoding EMPTY/FILL/WAIT_SWAP as a 2-bit typedef;
  - the bank localparams BANK0/BANK1;
  - the drop-counter width constant DROP_CNT_W=16.
- Sub-module bram_sdp(WIDTH, DEPTH, RD_LATENCY): single-clock simple dual-port array with one write port, registered read and an optional second read register.
- bram_sdp is instantiated twice, one per bank. The top level owns the FSM, the bank multiplexing and the valid pipeline.

Test Plan:
- Reset then idle -> o_wr_bank=0, o_rd_bank=1, o_frame_ready=0, o_overrun=0, o_rd_valid=0 for 10 cycles.
- Write addr 0..15 with data 16'h0A0+addr, pulse i_wr_frame_end, then i_rd_frame_start, then read addr 0..15 -> o_rd_bank=0, o_frame_ready=1, data 0x0A0..0x0AF returned RD_LATENCY cycles after each read, with o_rd_valid aligned. Run with RD_LATENCY=1 and RD_LATENCY=2.
- After i_wr_frame_end, issue 3 writes before i_rd_frame_start -> writes dropped, o_overrun=1, the other bank unchanged on readback; with FRAME_BRAM_DROP_CNT_EN, o_drop_cnt=3.
- Read issued on the swap edge at addr 5 -> returns old-bank word. The next read at addr 5 returns new-bank word.
- Hold i_en=0 while pulsing i_wr, i_rd, i_wr_frame_end and i_rd_frame_start -> no bank or state change, o_rd_valid=0, memory unchanged.
- Assert i_rst while in WAIT_SWAP -> banks return to 0/1, state EMPTY, o_overrun=0. A subsequent write to addr 7 of 12'h5A5, frame end and swap reads back 12'h5A5.

Source files
------------

// File: rtl/frame_bram_pingpong_pkg.sv
// Shared types and constants for the ping-pong frame buffer: FSM state encoding,
// bank identifiers and the width of the optional dropped-write counter.
package frame_bram_pkg;
   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      FILL      = 2'd1,
      WAIT_SWAP = 2'd2
   } state_t;

   localparam logic BANK0 = 1'b0;
   localparam logic BANK1 = 1'b1;

   localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/frame_bram_pingpong_bram_sdp.sv
// Single-clock simple dual-port RAM: one write port, registered read with an optional
// second output register; reads outside DEPTH return zero.
module bram_sdp #(
   parameter int WIDTH      = 12,
   parameter int DEPTH      = 307200,
   parameter int RD_LATENCY = 1,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [WIDTH-1:0]  o_rd_data
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_q1;
   logic             w_rd_in_range;

   assign w_rd_in_range = ({1'b0, i_rd_addr} < (ADDR_W+1)'(DEPTH));

   // Array itself is never reset so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_q1 <= '0;
      end else if (i_en) begin
         r_rd_q1 <= (i_re && w_rd_in_range) ? r_mem[i_rd_addr] : '0;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic [WIDTH-1:0] r_rd_q2;
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_rd_q2 <= '0;
            end else if (i_en) begin
               r_rd_q2 <= r_rd_q1;
            end
         end
         assign o_rd_data = r_rd_q2;
      end else begin : g_lat1
         assign o_rd_data = r_rd_q1;
      end
   endgenerate
endmodule

// File: rtl/frame_bram_pingpong.sv
// Double-buffered frame memory; banks swap on a frame-end/frame-start handshake. FRAME_BRAM_DROP_CNT_EN adds o_drop_cnt.
// States: EMPTY = no frame yet | FILL = frame shown to reader, next being written | WAIT_SWAP = full frame awaits reader
module frame_bram_pingpong
   import frame_bram_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter int DEPTH      = 307200,
   parameter int RD_LATENCY = 1,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]  i_wr_data,
   input  logic              i_wr_frame_end,
   input  logic              i_rd,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic              i_rd_frame_start,
   output logic [WIDTH-1:0]  o_rd_data,
   output logic              o_rd_valid,
   output logic              o_wr_bank,
   output logic              o_rd_bank,
   output logic              o_frame_ready,
   output logic              o_overrun
`ifdef FRAME_BRAM_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] o_drop_cnt
`endif
);
   generate
      if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
         $error("frame_bram_pingpong: RD_LATENCY must be 1 or 2");
      end
   endgenerate

   state_t           r_state;
   logic             r_wr_bank;
   logic             r_rd_bank;
   logic             r_frame_ready;
   logic             r_overrun;
   logic             r_rd_sel1;
   logic             r_rd_valid;
   logic             w_rd_sel_out;
   logic             w_wr_in_range;
   logic             w_wr_ok;
   logic             w_wr_drop;
   logic             w_rd_ok;
   logic [WIDTH-1:0] w_bank0_data;
   logic [WIDTH-1:0] w_bank1_data;
`ifdef FRAME_BRAM_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] r_drop_cnt;
`endif

   assign w_wr_in_range = ({1'b0, i_wr_addr} < (ADDR_W+1)'(DEPTH));
   assign w_wr_ok       = i_en & i_wr & (r_state != WAIT_SWAP) & w_wr_in_range;
   assign w_wr_drop     = i_en & i_wr & (r_state == WAIT_SWAP);
   assign w_rd_ok       = i_en & i_rd;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= EMPTY;
         r_wr_bank     <= BANK0;
         r_rd_bank     <= BANK1;
         r_frame_ready <= 1'b0;
         r_overrun     <= 1'b0;
`ifdef FRAME_BRAM_DROP_CNT_EN
         r_drop_cnt    <= '0;
`endif
      end else if (i_en) begin
         if (w_wr_drop) begin
            r_overrun <= 1'b1;
`ifdef FRAME_BRAM_DROP_CNT_EN
            if (r_drop_cnt != '1) begin
               r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
`endif
         end
         case (r_state)
            EMPTY, FILL: begin
               if (i_wr_frame_end) begin
                  r_state <= WAIT_SWAP;
               end
            end
            WAIT_SWAP: begin
               if (i_rd_frame_start) begin
                  r_state       <= FILL;
                  r_rd_bank     <= r_wr_bank;
                  r_wr_bank     <= ~r_wr_bank;
                  r_frame_ready <= 1'b1;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

   // Bank select travels with the read so a swap mid-flight cannot redirect it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_sel1 <= 1'b0;
      end else if (i_en) begin
         r_rd_sel1 <= r_rd_bank;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_vld2
         logic r_rd_vld1;
         logic r_rd_sel2;
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_rd_vld1  <= 1'b0;
               r_rd_sel2  <= 1'b0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= i_en & r_rd_vld1;
               if (i_en) begin
                  r_rd_vld1 <= i_rd;
                  r_rd_sel2 <= r_rd_sel1;
               end
            end
         end
         assign w_rd_sel_out = r_rd_sel2;
      end else begin : g_vld1
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_ok;
            end
         end
         assign w_rd_sel_out = r_rd_sel1;
      end
   endgenerate

   bram_sdp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)) u_bank0 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_we      (w_wr_ok & (r_wr_bank == BANK0)),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_re      (w_rd_ok & (r_rd_bank == BANK0)),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (w_bank0_data)
   );

   bram_sdp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)) u_bank1 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_we      (w_wr_ok & (r_wr_bank == BANK1)),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_re      (w_rd_ok & (r_rd_bank == BANK1)),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (w_bank1_data)
   );

   assign o_rd_data     = (w_rd_sel_out == BANK1) ? w_bank1_data : w_bank0_data;
   assign o_rd_valid    = r_rd_valid;
   assign o_wr_bank     = r_wr_bank;
   assign o_rd_bank     = r_rd_bank;
   assign o_frame_ready = r_frame_ready;
   assign o_overrun     = r_overrun;
`ifdef FRAME_BRAM_DROP_CNT_EN
   assign o_drop_cnt    = r_drop_cnt;
`endif
endmodule

// File: tb/tb_frame_bram_pingpong.sv
// Bench for frame_bram_pingpong: RD_LATENCY=1 and RD_LATENCY=2 instances side by side,
// compared against a frame-level reference model of the two banks and the swap handshake.
module tb_frame_bram_pingpong;
   localparam int WIDTH = 12;
   localparam int DEPTH = 24;
   localparam int AW    = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst, en, wr, fe, rd, fs;
   logic [AW-1:0]    waddr, raddr;
   logic [WIDTH-1:0] wdata;

   logic [WIDTH-1:0] dout [2];
   logic vld [2], wbk [2], rbk [2], frdy [2], ovr [2];
`ifdef FRAME_BRAM_DROP_CNT_EN
   logic [15:0] dcnt [2];
`endif

   int checks = 0;
   int errors = 0;

   // reference model
   logic [WIDTH-1:0] m_mem   [2][DEPTH];
   bit               m_known [2][DEPTH];
   bit m_wait, m_wb, m_rb, m_ready, m_ov;
   int m_drops;
   bit               e_v  [2];
   logic [WIDTH-1:0] e_d  [2];
   bit               e_dk [2];
   bit               p_v, p_dk;
   logic [WIDTH-1:0] p_d;

   always #5 clk = ~clk;

   frame_bram_pingpong #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(1)) u_lat1 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_wr(wr), .i_wr_addr(waddr), .i_wr_data(wdata),
      .i_wr_frame_end(fe), .i_rd(rd), .i_rd_addr(raddr), .i_rd_frame_start(fs),
      .o_rd_data(dout[0]), .o_rd_valid(vld[0]), .o_wr_bank(wbk[0]), .o_rd_bank(rbk[0]),
      .o_frame_ready(frdy[0]), .o_overrun(ovr[0])
`ifdef FRAME_BRAM_DROP_CNT_EN
      , .o_drop_cnt(dcnt[0])
`endif
   );

   frame_bram_pingpong #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(2)) u_lat2 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_wr(wr), .i_wr_addr(waddr), .i_wr_data(wdata),
      .i_wr_frame_end(fe), .i_rd(rd), .i_rd_addr(raddr), .i_rd_frame_start(fs),
      .o_rd_data(dout[1]), .o_rd_valid(vld[1]), .o_wr_bank(wbk[1]), .o_rd_bank(rbk[1]),
      .o_frame_ready(frdy[1]), .o_overrun(ovr[1])
`ifdef FRAME_BRAM_DROP_CNT_EN
      , .o_drop_cnt(dcnt[1])
`endif
   );

   // Drive one cycle, advance the model across the edge, then settle for sampling.
   task automatic tick(input bit t_rst, input bit t_en, input bit t_wr, input int t_wa,
                       input int t_wd, input bit t_fe, input bit t_rd, input int t_ra,
                       input bit t_fs);
      bit               rv, rk;
      logic [WIDTH-1:0] rdv;
      rst = t_rst; en = t_en; wr = t_wr; waddr = AW'(t_wa); wdata = WIDTH'(t_wd);
      fe = t_fe; rd = t_rd; raddr = AW'(t_ra); fs = t_fs;
      @(posedge clk);
      if (t_rst) begin
         m_wait = 0; m_wb = 0; m_rb = 1; m_ready = 0; m_ov = 0; m_drops = 0;
         e_v[0] = 0; e_v[1] = 0; e_dk[0] = 1; e_dk[1] = 1; e_d[0] = '0; e_d[1] = '0;
         p_v = 0; p_dk = 1; p_d = '0;
      end else if (!t_en) begin
         e_v[0] = 0; e_v[1] = 0;
      end else begin
         rv = t_rd;
         if (t_ra >= DEPTH) begin
            rdv = '0; rk = 1;
         end else begin
            rdv = m_mem[m_rb][t_ra]; rk = m_known[m_rb][t_ra];
         end
         e_v[1] = p_v; e_d[1] = p_d; e_dk[1] = p_dk;
         p_v = rv; p_d = rdv; p_dk = rk;
         e_v[0] = rv; e_d[0] = rdv; e_dk[0] = rk;
         if (t_wr) begin
            if (m_wait) begin
               m_ov = 1;
               if (m_drops < 65535) m_drops++;
            end else if (t_wa < DEPTH) begin
               m_mem[m_wb][t_wa] = WIDTH'(t_wd);
               m_known[m_wb][t_wa] = 1;
            end
         end
         if (m_wait) begin
            if (t_fs) begin
               m_wait = 0; m_rb = m_wb; m_wb = !m_wb; m_ready = 1;
            end
         end else if (t_fe) begin
            m_wait = 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 10; c++) begin
         tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (wbk[k] !== 1'b0 || rbk[k] !== 1'b1 || frdy[k] !== 1'b0 || ovr[k] !== 1'b0 || vld[k] !== 1'b0) begin
               errors++;
               $display("FAIL reset_idle lat%0d cyc%0d got wb=%b rb=%b rdy=%b ov=%b v=%b want 0 1 0 0 0",
                        k + 1, c, wbk[k], rbk[k], frdy[k], ovr[k], vld[k]);
            end
         end
      end
   endtask

   task automatic test_basic();
      for (int a = 0; a < 16; a++) tick(0, 1, 1, a, 'h0A0 + a, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (rbk[0] !== 1'b0 || wbk[0] !== 1'b1 || frdy[0] !== 1'b1) begin
         errors++;
         $display("FAIL basic_swap got rb=%b wb=%b rdy=%b want 0 1 1", rbk[0], wbk[0], frdy[0]);
      end
      for (int a = 0; a <= 16; a++) begin
         tick(0, 1, 0, 0, 0, 0, (a < 16), a, 0);
         if (a < 16) begin
            checks++;
            if (vld[0] !== 1'b1 || dout[0] !== WIDTH'('h0A0 + a)) begin
               errors++;
               $display("FAIL basic_rd_lat1 addr%0d got v=%b d=%h want 1 %h", a, vld[0], dout[0], 'h0A0 + a);
            end
         end
         if (a > 0) begin
            checks++;
            if (vld[1] !== 1'b1 || dout[1] !== WIDTH'('h0A0 + a - 1)) begin
               errors++;
               $display("FAIL basic_rd_lat2 addr%0d got v=%b d=%h want 1 %h", a - 1, vld[1], dout[1], 'h0A0 + a - 1);
            end
         end
      end
      tick(0, 1, 0, 0, 0, 0, 1, DEPTH + 3, 0);
      checks++;
      if (vld[0] !== 1'b1 || dout[0] !== '0) begin
         errors++;
         $display("FAIL oor_rd_lat1 got v=%b d=%h want 1 000", vld[0], dout[0]);
      end
      tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (vld[1] !== 1'b1 || dout[1] !== '0 || vld[0] !== 1'b0) begin
         errors++;
         $display("FAIL oor_rd_lat2 got v=%b d=%h v1=%b want 1 000 0", vld[1], dout[1], vld[0]);
      end
   endtask

   task automatic test_overrun();
      for (int a = 0; a < 8; a++) tick(0, 1, 1, a, 'h1B0 + a, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 1, 0, 0, 0);
      for (int a = 0; a < 3; a++) tick(0, 1, 1, a, 'hFFF, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ovr[k] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag lat%0d got %b want 1", k + 1, ovr[k]);
         end
`ifdef FRAME_BRAM_DROP_CNT_EN
         checks++;
         if (dcnt[k] !== 16'd3) begin
            errors++;
            $display("FAIL drop_cnt lat%0d got %0d want 3", k + 1, dcnt[k]);
         end
`endif
      end
      tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (rbk[1] !== 1'b1 || wbk[1] !== 1'b0) begin
         errors++;
         $display("FAIL overrun_swap got rb=%b wb=%b want 1 0", rbk[1], wbk[1]);
      end
      for (int a = 0; a <= 3; a++) begin
         tick(0, 1, 0, 0, 0, 0, (a < 3), a, 0);
         if (a < 3) begin
            checks++;
            if (vld[0] !== 1'b1 || dout[0] !== WIDTH'('h1B0 + a)) begin
               errors++;
               $display("FAIL overrun_rd_lat1 addr%0d got v=%b d=%h want 1 %h", a, vld[0], dout[0], 'h1B0 + a);
            end
         end
         if (a > 0) begin
            checks++;
            if (vld[1] !== 1'b1 || dout[1] !== WIDTH'('h1B0 + a - 1)) begin
               errors++;
               $display("FAIL overrun_rd_lat2 addr%0d got v=%b d=%h want 1 %h", a - 1, vld[1], dout[1], 'h1B0 + a - 1);
            end
         end
      end
   endtask

   task automatic test_swap_read();
      tick(0, 1, 1, 5, 'h2C5, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0, 1, 5, 1);
      checks++;
      if (vld[0] !== 1'b1 || dout[0] !== 12'h1B5 || rbk[0] !== 1'b0) begin
         errors++;
         $display("FAIL swap_edge_rd_lat1 got v=%b d=%h rb=%b want 1 1b5 0", vld[0], dout[0], rbk[0]);
      end
      tick(0, 1, 0, 0, 0, 0, 1, 5, 0);
      checks++;
      if (vld[0] !== 1'b1 || dout[0] !== 12'h2C5 || vld[1] !== 1'b1 || dout[1] !== 12'h1B5) begin
         errors++;
         $display("FAIL post_swap_rd got v1=%b d1=%h v2=%b d2=%h want 1 2c5 1 1b5", vld[0], dout[0], vld[1], dout[1]);
      end
      tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (vld[1] !== 1'b1 || dout[1] !== 12'h2C5) begin
         errors++;
         $display("FAIL post_swap_rd_lat2 got v=%b d=%h want 1 2c5", vld[1], dout[1]);
      end
   endtask

   task automatic test_enable();
      for (int c = 0; c < 5; c++) begin
         tick(0, 0, 1, 6, 'hBAD, 1, 1, 6, 1);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (vld[k] !== 1'b0 || wbk[k] !== 1'b1 || rbk[k] !== 1'b0) begin
               errors++;
               $display("FAIL en_low lat%0d cyc%0d got v=%b wb=%b rb=%b want 0 1 0", k + 1, c, vld[k], wbk[k], rbk[k]);
            end
         end
      end
      tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (rbk[0] !== 1'b0 || wbk[0] !== 1'b1) begin
         errors++;
         $display("FAIL en_low_state got rb=%b wb=%b want 0 1", rbk[0], wbk[0]);
      end
      tick(0, 1, 0, 0, 0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
      tick(0, 1, 0, 0, 0, 0, 1, 6, 0);
      checks++;
      if (rbk[0] !== 1'b1 || vld[0] !== 1'b1 || dout[0] !== 12'h1B6) begin
         errors++;
         $display("FAIL en_low_mem_lat1 got rb=%b v=%b d=%h want 1 1 1b6", rbk[0], vld[0], dout[0]);
      end
      tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (vld[1] !== 1'b1 || dout[1] !== 12'h1B6) begin
         errors++;
         $display("FAIL en_low_mem_lat2 got v=%b d=%h want 1 1b6", vld[1], dout[1]);
      end
   endtask

   task automatic test_reset_wait();
      tick(0, 1, 0, 0, 0, 1, 0, 0, 0);
      tick(0, 1, 1, 3, 'h333, 0, 0, 0, 0);
      tick(1, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (wbk[k] !== 1'b0 || rbk[k] !== 1'b1 || ovr[k] !== 1'b0 || frdy[k] !== 1'b0 || vld[k] !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_wait lat%0d got wb=%b rb=%b ov=%b rdy=%b v=%b want 0 1 0 0 0",
                     k + 1, wbk[k], rbk[k], ovr[k], frdy[k], vld[k]);
         end
`ifdef FRAME_BRAM_DROP_CNT_EN
         checks++;
         if (dcnt[k] !== 16'd0) begin
            errors++;
            $display("FAIL rst_drop_cnt lat%0d got %0d want 0", k + 1, dcnt[k]);
         end
`endif
      end
      tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (rbk[0] !== 1'b1 || frdy[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_pending_swap got rb=%b rdy=%b want 1 0", rbk[0], frdy[0]);
      end
      tick(0, 1, 1, 7, 'h5A5, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 1, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0, 0, 0, 1);
      tick(0, 1, 0, 0, 0, 0, 1, 7, 0);
      checks++;
      if (rbk[0] !== 1'b0 || frdy[0] !== 1'b1 || vld[0] !== 1'b1 || dout[0] !== 12'h5A5) begin
         errors++;
         $display("FAIL rst_then_frame_lat1 got rb=%b rdy=%b v=%b d=%h want 0 1 1 5a5", rbk[0], frdy[0], vld[0], dout[0]);
      end
      tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (vld[1] !== 1'b1 || dout[1] !== 12'h5A5) begin
         errors++;
         $display("FAIL rst_then_frame_lat2 got v=%b d=%h want 1 5a5", vld[1], dout[1]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         tick($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 31)), int'($urandom_range(0, 4095)), $urandom_range(0, 15) == 0,
              $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), $urandom_range(0, 7) == 0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (vld[k] !== e_v[k]) begin
               errors++;
               $display("FAIL rand_valid lat%0d cyc%0d got %b want %b", k + 1, c, vld[k], e_v[k]);
            end
            if (e_v[k] && e_dk[k]) begin
               checks++;
               if (dout[k] !== e_d[k]) begin
                  errors++;
                  $display("FAIL rand_data lat%0d cyc%0d got %h want %h", k + 1, c, dout[k], e_d[k]);
               end
            end
            checks++;
            if (wbk[k] !== m_wb || rbk[k] !== m_rb || frdy[k] !== m_ready || ovr[k] !== m_ov) begin
               errors++;
               $display("FAIL rand_ctrl lat%0d cyc%0d got wb=%b rb=%b rdy=%b ov=%b want %b %b %b %b",
                        k + 1, c, wbk[k], rbk[k], frdy[k], ovr[k], m_wb, m_rb, m_ready, m_ov);
            end
`ifdef FRAME_BRAM_DROP_CNT_EN
            checks++;
            if (dcnt[k] !== 16'(m_drops)) begin
               errors++;
               $display("FAIL rand_drop_cnt lat%0d cyc%0d got %0d want %0d", k + 1, c, dcnt[k], m_drops);
            end
`endif
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_swap_read();
      test_enable();
      test_reset_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
